// File: rtl/alu_pkg.sv
// alu_pkg: ALUOp codes, RV32I opcodes, operand selects and the decoded control bundle.
package alu_pkg;
  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_AND = 4'b0010;
  localparam logic [3:0] ALU_OR  = 4'b0011;
  localparam logic [3:0] ALU_XOR = 4'b0100;
  localparam logic [3:0] ALU_SLL = 4'b0101;
  localparam logic [3:0] ALU_SRL = 4'b0110;
  localparam logic [3:0] ALU_SRA = 4'b0111;
  localparam logic [3:0] ALU_SLT = 4'b1000;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [1:0] SRC_A_RS1  = 2'd0;
  localparam logic [1:0] SRC_A_ZERO = 2'd1;
  localparam logic [1:0] SRC_A_PC   = 2'd2;
  typedef struct packed {
    logic [3:0]  alu_op;
    logic [1:0]  src_a;
    logic        src_b_imm;
    logic [31:0] imm;
    logic        reg_write;
    logic        branch;
    logic        br_on_zero;
    logic        illegal;
  } alu_ctrl_t;
  typedef enum logic [1:0] {EMPTY, ONE, TWO} skid_state_t;
endpackage

// File: rtl/alu_op_decode_comb.sv
// alu_op_decode_comb: pure combinational RV32I instruction to ALU control bundle decode.
module alu_op_decode_comb
  import alu_pkg::*;
(
  input  logic [31:0] instr,
  output alu_ctrl_t   ctrl
);
  logic [6:0] opc, f7;
  logic [2:0] f3;
  logic [31:0] i_imm, s_imm, b_imm, u_imm;
  logic is_op, ill;
  assign opc = instr[6:0];
  assign f3 = instr[14:12];
  assign f7 = instr[31:25];
  assign is_op = opc == OPC_OP;
  assign i_imm = {{20{instr[31]}}, instr[31:20]};
  assign s_imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign b_imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign u_imm = {instr[31:12], 12'b0};
  always_comb begin
    ctrl = '0;
    ill = 1'b0;
    case (opc)
      OPC_OP, OPC_OP_IMM: begin
        ctrl.alu_op = f3 == 3'b000 ? ((is_op && f7[5]) ? ALU_SUB : ALU_ADD) :
                      f3 == 3'b111 ? ALU_AND :
                      f3 == 3'b110 ? ALU_OR :
                      f3 == 3'b100 ? ALU_XOR :
                      f3 == 3'b001 ? ALU_SLL :
                      f3 == 3'b101 ? (f7[5] ? ALU_SRA : ALU_SRL) : ALU_SLT;
        ctrl.src_b_imm = !is_op;
        ctrl.imm = is_op ? '0 : i_imm;
        ctrl.reg_write = 1'b1;
        // immediate shifts only admit the SRL/SRA funct7 encodings
        ill = f3 == 3'b011 || (!is_op && f3[1:0] == 2'b01 && f7 != 7'b0000000 && f7 != 7'b0100000);
      end
      OPC_LOAD: begin
        ctrl.src_b_imm = 1'b1;
        ctrl.imm = i_imm;
        ctrl.reg_write = 1'b1;
      end
      OPC_STORE: begin
        ctrl.src_b_imm = 1'b1;
        ctrl.imm = s_imm;
      end
      OPC_BRANCH: begin
        ctrl.alu_op = f3[2] ? ALU_SLT : ALU_SUB;
        ctrl.br_on_zero = f3[2] ^ ~f3[0];
        ctrl.imm = b_imm;
        ctrl.branch = 1'b1;
        ill = f3[1];
      end
      OPC_LUI, OPC_AUIPC: begin
        ctrl.src_a = opc == OPC_LUI ? SRC_A_ZERO : SRC_A_PC;
        ctrl.src_b_imm = 1'b1;
        ctrl.imm = u_imm;
        ctrl.reg_write = 1'b1;
      end
      default: ill = 1'b1;
    endcase
    if (ill) begin
      ctrl = '0;
      ctrl.illegal = 1'b1;
    end
  end
endmodule

// File: rtl/alu_op_encoder.sv
// alu_op_encoder: registered instruction-to-ALU-control stage with valid/ready and a 2-entry skid buffer.
module alu_op_encoder
  import alu_pkg::*;
#(
  parameter int XLEN = 32,
  parameter bit SKID_EN = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [3:0]      out_alu_op,
  output logic [1:0]      out_src_a,
  output logic            out_src_b_imm,
  output logic [XLEN-1:0] out_imm,
  output logic            out_reg_write,
  output logic            out_branch,
  output logic            out_br_on_zero,
  output logic            out_illegal
);
  skid_state_t state, state_next;
  alu_ctrl_t dec, e0, e1;
  logic rdy_q, acc, con;
  alu_op_decode_comb u_dec (.instr(in_instr), .ctrl(dec));
  assign out_valid = state != EMPTY;
  // without the skid entry the stage accepts only when its single slot frees this cycle
  assign in_ready = SKID_EN ? rdy_q : (state == EMPTY || out_ready);
  assign acc = in_valid && in_ready;
  assign con = out_valid && out_ready;
  always_comb begin
    state_next = state;
    case (state)
      EMPTY: state_next = acc ? ONE : EMPTY;
      ONE: state_next = (acc && !con) ? TWO : (con && !acc) ? EMPTY : ONE;
      TWO: state_next = con ? ONE : TWO;
      default: state_next = EMPTY;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= EMPTY;
      rdy_q <= 1'b1;
      e0 <= '0;
      e1 <= '0;
    end else begin
      state <= state_next;
      rdy_q <= state_next != TWO;
      if ((state == EMPTY && acc) || (state == ONE && acc && con) || (state == TWO && con))
        e0 <= state == TWO ? e1 : dec;
      if (state == ONE && acc && !con)
        e1 <= dec;
    end
  end
  assign out_alu_op = e0.alu_op;
  assign out_src_a = e0.src_a;
  assign out_src_b_imm = e0.src_b_imm;
  assign out_imm = e0.imm;
  assign out_reg_write = e0.reg_write;
  assign out_branch = e0.branch;
  assign out_br_on_zero = e0.br_on_zero;
  assign out_illegal = e0.illegal;
endmodule

// File: tb/tb_alu_op_encoder.sv
// tb_alu_op_encoder: directed vectors with hand-computed decode results and skid-buffer handshake checks.
module tb_alu_op_encoder;
  logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, out_ready = 1'b0;
  logic [31:0] in_instr = '0;
  logic in_ready, out_valid, out_src_b_imm, out_reg_write, out_branch, out_br_on_zero, out_illegal;
  logic [3:0] out_alu_op;
  logic [1:0] out_src_a;
  logic [31:0] out_imm;
  int n_chk = 0, n_fail = 0;

  alu_op_encoder dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .out_valid(out_valid), .out_ready(out_ready), .out_alu_op(out_alu_op), .out_src_a(out_src_a),
    .out_src_b_imm(out_src_b_imm), .out_imm(out_imm), .out_reg_write(out_reg_write),
    .out_branch(out_branch), .out_br_on_zero(out_br_on_zero), .out_illegal(out_illegal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [31:0] ins);
    in_valid = 1'b1;
    in_instr = ins;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_alu_op", out_alu_op, 0);
    chk("rst_imm", out_imm, 0);
    out_ready = 1'b1;
    send(32'h40B50533);
    chk("sub_valid", out_valid, 1);
    chk("sub_op", out_alu_op, 4'b0001);
    chk("sub_bimm", out_src_b_imm, 0);
    chk("sub_rw", out_reg_write, 1);
    chk("sub_ill", out_illegal, 0);
    send(32'h4055D513);
    chk("srai_op", out_alu_op, 4'b0111);
    chk("srai_bimm", out_src_b_imm, 1);
    chk("srai_imm", out_imm, 32'h00000405);
    send(32'h0000B533);
    chk("sltu_ill", out_illegal, 1);
    chk("sltu_rw", out_reg_write, 0);
    chk("sltu_valid", out_valid, 1);
    send(32'h00B55463);
    chk("bge_op", out_alu_op, 4'b1000);
    chk("bge_br", out_branch, 1);
    chk("bge_boz", out_br_on_zero, 1);
    chk("bge_imm", out_imm, 32'h00000008);
    chk("bge_bimm", out_src_b_imm, 0);
    send(32'h00B51463);
    chk("bne_op", out_alu_op, 4'b0001);
    chk("bne_boz", out_br_on_zero, 0);
    send(32'h123452B7);
    chk("lui_srca", out_src_a, 1);
    chk("lui_imm", out_imm, 32'h12345000);
    send(32'h00001297);
    chk("auipc_srca", out_src_a, 2);
    chk("auipc_imm", out_imm, 32'h00001000);
    send(32'hFFC5A503);
    chk("lw_imm", out_imm, 32'hFFFFFFFC);
    chk("lw_rw", out_reg_write, 1);
    send(32'h00B52223);
    chk("sw_imm", out_imm, 32'h00000004);
    chk("sw_rw", out_reg_write, 0);
    send(32'h00000001);
    chk("rvc_ill", out_illegal, 1);
    chk("rvc_op", out_alu_op, 0);
    @(negedge clk);
    chk("drain_valid", out_valid, 0);
    out_ready = 1'b0;
    send(32'h00B50533);
    chk("bp1_ready", in_ready, 1);
    chk("bp1_op", out_alu_op, 4'b0000);
    send(32'h40B50533);
    chk("bp2_ready", in_ready, 0);
    chk("bp2_op", out_alu_op, 4'b0000);
    in_valid = 1'b1;
    in_instr = 32'h4055D513;
    @(negedge clk);
    chk("bp3_ready", in_ready, 0);
    chk("bp3_op_stable", out_alu_op, 4'b0000);
    chk("bp3_imm_stable", out_imm, 0);
    out_ready = 1'b1;
    @(negedge clk);
    chk("fifo_b_op", out_alu_op, 4'b0001);
    chk("fifo_b_ready", in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    chk("fifo_c_op", out_alu_op, 4'b0111);
    chk("fifo_c_imm", out_imm, 32'h00000405);
    @(negedge clk);
    chk("fifo_empty", out_valid, 0);
    out_ready = 1'b0;
    send(32'h00B50533);
    send(32'h40B50533);
    chk("pre_rst_full", in_ready, 0);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_valid", out_valid, 0);
    chk("midrst_ready", in_ready, 1);
    rst = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_rst_valid", out_valid, 0);
    chk("post_rst_op", out_alu_op, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
